blink_sequencer: RTL and testbench

- Timed LED pattern controller: sequences the prescaled tick datapath to produce N on/off blinks, an optional pause, then done or repeat.
- Replaces free-running cascaded counter dividers with one configurable prescaler and a phase FSM.
- Sits between board CLK and the LED pin, or any slow indicator output.
- Start/stop are pulse requests from a host or debounced buttons.

---
 rtl/blink_sequencer_pkg.sv | 23 ++
 rtl/blink_sequencer_if.sv | 25 ++
 rtl/blink_sequencer_tick_gen.sv | 27 ++
 rtl/blink_sequencer.sv | 170 +++++++++++++++++
 tb/tb_blink_sequencer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/blink_sequencer_pkg.sv
// Shared types and helpers for the blink sequencer and its tick generator.
package blink_pkg;

    localparam int CFG_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ON    = 2'd1,
        ST_OFF   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    // Clocks per tick; integer division, caller keeps the result >= 2.
    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Prescaler counter width for a given divide ratio.
    function automatic int presc_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/blink_sequencer_if.sv
// Request/config/status bundle between a host and the blink sequencer.
interface blink_sequencer_if #(
    parameter int CFG_W = 8
) ();
    logic             start;
    logic             stop;
    logic [3:0]       blink_count;
    logic [CFG_W-1:0] on_ticks;
    logic [CFG_W-1:0] off_ticks;
    logic [CFG_W-1:0] pause_ticks;
    logic             repeat_en;
    logic             LED;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, blink_count, on_ticks, off_ticks, pause_ticks, repeat_en,
        input  LED, busy, done
    );

    modport slave (
        input  start, stop, blink_count, on_ticks, off_ticks, pause_ticks, repeat_en,
        output LED, busy, done
    );
endinterface

// File: rtl/blink_sequencer_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the wrap cycle as a tick.
module tick_gen
    import blink_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = presc_w(DIV);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    // Count while enabled, wrap on the tick; clear restarts phase timing exactly.
    always_ff @(posedge CLK) begin
        if (!RST_N || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/blink_sequencer.sv
// Blink sequencer: N on/off blinks, optional pause, then done or repeat.
//
//  state    | meaning
//  ST_IDLE  | waiting for start; prescaler held clear
//  ST_ON    | LED high for on_ticks
//  ST_OFF   | LED low for off_ticks, counts down remaining blinks
//  ST_PAUSE | LED low for pause_ticks after the last blink
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 10,
    parameter int CFG_W   = CFG_W_DEFAULT
) (
    input logic              CLK,
    input logic              RST_N,
    blink_sequencer_if.slave bus
);
    localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);

    state_t           state_q, state_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CFG_W-1:0] phase_q, phase_d;
    logic [3:0]       rem_q, rem_d;
    logic [3:0]       blinks_q;
    logic [CFG_W-1:0] on_q, off_q, pause_q;
    logic             rpt_q;
    logic             latch, presc_clr, seq_end, tick, phase_last;
    logic [CFG_W-1:0] on_in;
    logic [3:0]       rem_dec;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (presc_clr),
        .en    (busy_q),
        .tick  (tick)
    );

    // Zero-length on phase is stretched to one tick.
    assign on_in      = (bus.on_ticks == '0) ? CFG_W'(1) : bus.on_ticks;
    assign phase_last = tick && (phase_q == CFG_W'(1));
    assign rem_dec    = (rem_q != 4'd0) ? rem_q - 4'd1 : 4'd0;

    // Next-state, phase counter and output decode; stop overrides everything.
    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        phase_d   = phase_q;
        rem_d     = rem_q;
        latch     = 1'b0;
        presc_clr = 1'b0;
        seq_end   = 1'b0;

        if (state_q != ST_IDLE && tick && !phase_last) begin
            phase_d = phase_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                presc_clr = 1'b1;
                if (bus.start && !bus.stop) begin
                    if (bus.blink_count != 4'd0) begin
                        latch   = 1'b1;
                        state_d = ST_ON;
                        led_d   = 1'b1;
                        busy_d  = 1'b1;
                        rem_d   = bus.blink_count;
                        phase_d = on_in;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ON: begin
                if (phase_last) begin
                    state_d = ST_OFF;
                    led_d   = 1'b0;
                    phase_d = off_q;
                end
            end
            ST_OFF: begin
                if (phase_last) begin
                    rem_d = rem_dec;
                    if (rem_dec != 4'd0) begin
                        state_d = ST_ON;
                        led_d   = 1'b1;
                        phase_d = on_q;
                    end else if (pause_q != '0) begin
                        state_d = ST_PAUSE;
                        phase_d = pause_q;
                    end else begin
                        seq_end = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (phase_last) begin
                    seq_end = 1'b1;
                end
            end
        endcase

        if (seq_end) begin
            if (rpt_q) begin
                state_d = ST_ON;
                led_d   = 1'b1;
                rem_d   = blinks_q;
                phase_d = on_q;
            end else begin
                state_d = ST_IDLE;
                led_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end

        if (bus.stop && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            led_d     = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            presc_clr = 1'b1;
        end
    end

    // State, output and counter registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            phase_q <= '0;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
        end
    end

    // Config snapshot taken on an accepted start; off is clamped like on.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            blinks_q <= 4'd0;
            on_q     <= '0;
            off_q    <= '0;
            pause_q  <= '0;
            rpt_q    <= 1'b0;
        end else if (latch) begin
            blinks_q <= bus.blink_count;
            on_q     <= on_in;
            off_q    <= (bus.off_ticks == '0) ? CFG_W'(1) : bus.off_ticks;
            pause_q  <= bus.pause_ticks;
            rpt_q    <= bus.repeat_en;
        end
    end

    assign bus.LED  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_blink_sequencer.sv
// Directed and randomized checks of blink_sequencer against a cycle-waveform model.
module tb_blink_sequencer;
    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int TDIV    = CLK_HZ / TICK_HZ;
    localparam int MAXC    = 600;

    logic CLK;
    logic RST_N;
    int   checks   = 0;
    int   failures = 0;

    logic [2:0] exp_v [0:MAXC];

    blink_sequencer_if #(.CFG_W(8)) bus ();

    blink_sequencer #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .CFG_W   (8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed{LED,busy,done}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected {LED,busy,done} per cycle for a run started at cycle 0;
    // a stop (or reset) asserted in cycle s blanks everything from s+1.
    task automatic build_expect(input int bc, input int on, input int off, input int pa,
                                input bit rpt, input int stop_at);
        int c;
        int on_len;
        int off_len;
        for (int i = 0; i <= MAXC; i++) exp_v[i] = 3'b000;
        on_len  = ((on == 0) ? 1 : on) * TDIV;
        off_len = ((off == 0) ? 1 : off) * TDIV;
        c = 1;
        if (bc == 0) begin
            exp_v[1] = 3'b001;
        end else begin
            do begin
                for (int b = 0; b < bc; b++) begin
                    for (int k = 0; k < on_len; k++) begin
                        if (c <= MAXC) exp_v[c] = 3'b110;
                        c++;
                    end
                    for (int k = 0; k < off_len; k++) begin
                        if (c <= MAXC) exp_v[c] = 3'b010;
                        c++;
                    end
                end
                for (int k = 0; k < pa * TDIV; k++) begin
                    if (c <= MAXC) exp_v[c] = 3'b010;
                    c++;
                end
            end while (rpt && c <= MAXC);
            if (!rpt && c <= MAXC) exp_v[c] = 3'b001;
        end
        if (stop_at >= 0) begin
            for (int i = stop_at + 1; i <= MAXC; i++) exp_v[i] = 3'b000;
        end
    endtask

    // Called at cycle 0 (just after an edge); drives one run and checks every cycle.
    task automatic run_case(input string tag, input int bc, input int on, input int off,
                            input int pa, input bit rpt, input int stop_at, input bit use_rst,
                            input int repulse_at, input int ncyc);
        build_expect(bc, on, off, pa, rpt, stop_at);
        for (int c = 0; c <= ncyc; c++) begin
            bus.start = (c == 0) || (c == repulse_at);
            if (c == 0) begin
                bus.blink_count = 4'(bc);
                bus.on_ticks    = 8'(on);
                bus.off_ticks   = 8'(off);
                bus.pause_ticks = 8'(pa);
                bus.repeat_en   = rpt;
            end
            if (c == repulse_at) begin
                bus.blink_count = 4'($urandom_range(0, 15));
                bus.on_ticks    = 8'($urandom_range(0, 9));
                bus.off_ticks   = 8'($urandom_range(0, 9));
                bus.pause_ticks = 8'($urandom_range(0, 9));
                bus.repeat_en   = 1'($urandom_range(0, 1));
            end
            if (use_rst) begin
                RST_N    = (c == stop_at) ? 1'b0 : 1'b1;
                bus.stop = 1'b0;
            end else begin
                RST_N    = 1'b1;
                bus.stop = (c == stop_at);
            end
            check($sformatf("%s c%0d", tag, c), {bus.LED, bus.busy, bus.done}, exp_v[c]);
            @(posedge CLK);
            #1;
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        RST_N     = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int bc, on, off, pa, st, nc;
        bit rpt;

        RST_N           = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.blink_count = 4'd0;
        bus.on_ticks    = 8'd0;
        bus.off_ticks   = 8'd0;
        bus.pause_ticks = 8'd0;
        bus.repeat_en   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset", {bus.LED, bus.busy, bus.done}, 3'b000);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("post_reset_idle", {bus.LED, bus.busy, bus.done}, 3'b000);

        run_case("basic",       2, 3, 2, 0, 1'b0, -1, 1'b0, -1, 110);
        run_case("pause",       1, 1, 1, 4, 1'b0, -1, 1'b0, -1, 70);
        run_case("repeat_stop", 1, 2, 2, 0, 1'b1, 55, 1'b0, -1, 70);
        run_case("zero_blinks", 0, 3, 3, 0, 1'b0, -1, 1'b0, -1, 20);
        run_case("zero_on",     1, 0, 1, 0, 1'b0, -1, 1'b0, -1, 30);
        run_case("zero_off",    1, 1, 0, 0, 1'b0, -1, 1'b0, -1, 30);
        run_case("start_stop",  2, 3, 2, 0, 1'b0, 0,  1'b0, -1, 30);
        run_case("repulse",     2, 3, 2, 0, 1'b0, -1, 1'b0, 15, 110);
        run_case("reset_mid",   2, 3, 2, 0, 1'b0, 25, 1'b1, -1, 40);
        run_case("after_reset", 2, 3, 2, 0, 1'b0, -1, 1'b0, -1, 110);

        for (int n = 0; n < 8; n++) begin
            bc  = $urandom_range(0, 4);
            on  = $urandom_range(0, 3);
            off = $urandom_range(0, 3);
            pa  = $urandom_range(0, 3);
            rpt = 1'($urandom_range(0, 1));
            if (rpt) begin
                st = $urandom_range(5, 200);
                nc = st + 10;
            end else begin
                st = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 150) : -1;
                nc = 280;
            end
            run_case($sformatf("rand%0d", n), bc, on, off, pa, rpt, st, 1'b0, -1, nc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
